// File: rtl/prog_expander.sv
// prog_expander: 4-bit I/O expander driven by a strobed nibble bus.
// A bus cycle is: prog_n falls with a command nibble on p2 ({op,addr}),
// p2 carries data (writes) or is driven by us (reads), prog_n rises.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   prog_n, p2_in   bus strobe and nibble input (asynchronous, synchronized here)
//   p2_out, p2_oe   read data and drive enable back onto the bus
//   port_in         pin sense, 4 bits per port
//   port_out        port output latches, 4 bits per port
//   port_oe         per-port drive enable (0 = input mode)
//   wr_stb          one-cycle pulse on the port being updated
//   err, err_clr    sticky short-strobe error and its clear
module prog_expander #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_W       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_PROG_CYC = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_n,
    input  logic [3:0]             p2_in,
    output logic [3:0]             p2_out,
    output logic                   p2_oe,
    input  logic [4*NUM_PORTS-1:0] port_in,
    output logic [4*NUM_PORTS-1:0] port_out,
    output logic [NUM_PORTS-1:0]   port_oe,
    output logic [NUM_PORTS-1:0]   wr_stb,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int CNT_W = $clog2(MIN_PROG_CYC + 1);
    localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_OR = 2'd2, OP_AND = 2'd3;

    typedef enum logic [2:0] {IDLE, CMD, RD_DRIVE, WR_WAIT, APPLY} state_t;

    state_t state, nxt;

    logic [SYNC_STAGES-1:0]      prog_sync;
    logic [SYNC_STAGES-1:0][3:0] p2_sync;
    logic [SYNC_STAGES-1:0]      sync_vld;
    logic                        prog_s, prog_d, armed;
    logic [3:0]                  p2_s;
    logic                        fall, rise, short_lo;
    logic [CNT_W-1:0]            lo_cnt;
    logic [1:0]                  op_q;
    logic [ADDR_W-1:0]           addr_q;
    logic                        addr_ok;
    logic                        rd_go, apply_go, set_err;

    assign prog_s = prog_sync[SYNC_STAGES-1];
    assign p2_s   = p2_sync[SYNC_STAGES-1];

    // Edge detection is held off until the synchronizer has flushed and a
    // genuine high level has been seen, so a strobe already low when reset
    // releases is not mistaken for the start of a bus cycle.
    assign fall     = armed & prog_d & ~prog_s;
    assign rise     = prog_s & ~prog_d;
    assign short_lo = int'(lo_cnt) < MIN_PROG_CYC;
    assign addr_ok  = int'(addr_q) < NUM_PORTS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_sync <= '1;
            p2_sync   <= '1;
            sync_vld  <= '0;
            prog_d    <= 1'b1;
            armed     <= 1'b0;
            lo_cnt    <= '0;
        end else begin
            prog_sync <= {prog_sync[SYNC_STAGES-2:0], prog_n};
            p2_sync   <= {p2_sync[SYNC_STAGES-2:0], p2_in};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            prog_d    <= prog_s;
            armed     <= armed | (sync_vld[SYNC_STAGES-1] & prog_s);
            // Saturating low-time counter; at the rising-edge cycle it holds
            // the number of cycles the strobe was seen low.
            if (!prog_s) begin
                if (short_lo) lo_cnt <= lo_cnt + CNT_W'(1);
            end else begin
                lo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        rd_go    = 1'b0;
        apply_go = 1'b0;
        set_err  = 1'b0;
        case (state)
            IDLE: if (fall) nxt = CMD;
            CMD: begin
                // A strobe only one cycle long ends here; otherwise branch.
                if (rise) begin
                    nxt = IDLE;
                    if (short_lo) set_err = 1'b1;
                    else if (op_q != OP_RD) begin
                        apply_go = 1'b1;
                        nxt      = APPLY;
                    end
                end else if (op_q == OP_RD) begin
                    rd_go = 1'b1;
                    nxt   = RD_DRIVE;
                end else begin
                    nxt = WR_WAIT;
                end
            end
            RD_DRIVE: if (rise) begin
                nxt     = IDLE;
                set_err = short_lo;
            end
            WR_WAIT: if (rise) begin
                if (short_lo) begin
                    set_err = 1'b1;
                    nxt     = IDLE;
                end else begin
                    apply_go = 1'b1;
                    nxt      = APPLY;
                end
            end
            APPLY:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Drop the bus drive in the very cycle the rising edge is seen.
    assign p2_oe = (state == RD_DRIVE) && addr_ok && !rise;

    // Port updates are registered on the transition into APPLY so the new
    // latch value and wr_stb are both visible during APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_RD;
            addr_q   <= '0;
            p2_out   <= '0;
            port_out <= '1;
            port_oe  <= '0;
            wr_stb   <= '0;
            err      <= 1'b0;
        end else begin
            wr_stb <= '0;
            p2_out <= '0;
            err    <= (err & ~err_clr) | set_err;
            if (state == IDLE && fall) begin
                op_q   <= p2_s[3:2];
                addr_q <= ADDR_W'(p2_s[1:0]);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (addr_ok && int'(addr_q) == i) begin
                    if (nxt == RD_DRIVE) p2_out <= port_in[4*i +: 4];
                    if (rd_go) port_oe[i] <= 1'b0;
                    if (apply_go) begin
                        case (op_q)
                            OP_OR:   port_out[4*i +: 4] <= port_out[4*i +: 4] | p2_s;
                            OP_AND:  port_out[4*i +: 4] <= port_out[4*i +: 4] & p2_s;
                            default: port_out[4*i +: 4] <= p2_s;
                        endcase
                        port_oe[i] <= 1'b1;
                        wr_stb[i]  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_expander.sv
`timescale 1ns/100ps
module tb_prog_expander;

    logic        clk = 1'b0;
    logic        rst_n, prog_n, err_clr;
    logic [3:0]  p2_in;
    logic [15:0] port_in;
    logic [11:0] port_in3;

    logic [3:0]  p2_out, p2_out3;
    logic        p2_oe, p2_oe3, err, err3;
    logic [15:0] port_out;
    logic [11:0] port_out3;
    logic [3:0]  port_oe, wr_stb;
    logic [2:0]  port_oe3, wr_stb3;

    int ntests = 0;
    int nfail  = 0;
    int bad3   = 0;
    logic win3 = 1'b0;
    logic p2_oe_d = 1'b0;

    typedef struct {int port; logic [3:0] val;} wexp_t;
    wexp_t      wq[$];
    logic [3:0] rq[$];

    always #62.5 clk = ~clk;   // 8 MHz

    prog_expander u_dut (
        .clk(clk), .rst_n(rst_n), .prog_n(prog_n), .p2_in(p2_in),
        .p2_out(p2_out), .p2_oe(p2_oe), .port_in(port_in), .port_out(port_out),
        .port_oe(port_oe), .wr_stb(wr_stb), .err(err), .err_clr(err_clr)
    );

    prog_expander #(.NUM_PORTS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .prog_n(prog_n), .p2_in(p2_in),
        .p2_out(p2_out3), .p2_oe(p2_oe3), .port_in(port_in3), .port_out(port_out3),
        .port_oe(port_oe3), .wr_stb(wr_stb3), .err(err3), .err_clr(err_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One bus cycle: command, then data, strobe low for lo clock cycles.
    task automatic bus(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d, input int lo);
        p2_in = {op, a};
        repeat (2) @(negedge clk);
        prog_n = 1'b0;
        @(negedge clk);
        p2_in = d;
        repeat (lo - 1) @(negedge clk);
        prog_n = 1'b1;
        repeat (2) @(negedge clk);
        p2_in = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT strobes a
    // port write or starts driving the bus.
    always @(negedge clk) begin
        if (!rst_n) begin
            p2_oe_d = 1'b0;
        end else begin
            if (wr_stb != 4'b0) begin
                if (wq.size() == 0) chk("unexpected_wr_stb", 32'(wr_stb), 32'h0);
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr_stb", 32'(wr_stb), 32'(4'b1 << e.port));
                    chk("port_out_nibble", 32'(port_out[4*e.port +: 4]), 32'(e.val));
                end
            end
            if (p2_oe && !p2_oe_d) begin
                if (rq.size() == 0) chk("unexpected_p2_oe", 32'(p2_oe), 32'h0);
                else begin
                    logic [3:0] v;
                    v = rq.pop_front();
                    chk("p2_out", 32'(p2_out), 32'(v));
                end
            end
            p2_oe_d = p2_oe;
            if (win3 && (p2_oe3 || wr_stb3 != 3'b0)) bad3++;
        end
    end

    initial begin
        rst_n = 1'b0; prog_n = 1'b1; p2_in = 4'hF; err_clr = 1'b0;
        port_in = 16'h0A53; port_in3 = 12'hA53;
        repeat (3) @(negedge clk);
        chk("rst_p2_oe", 32'(p2_oe), 32'h0);
        chk("rst_p2_out", 32'(p2_out), 32'h0);
        chk("rst_port_out", 32'(port_out), 32'hFFFF);
        chk("rst_port_oe", 32'(port_oe), 32'h0);
        chk("rst_wr_stb", 32'(wr_stb), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reads of ports 0..2
        rq.push_back(4'h3); bus(2'd0, 2'd0, 4'hF, 6);
        rq.push_back(4'h5); bus(2'd0, 2'd1, 4'hF, 6);
        rq.push_back(4'hA); bus(2'd0, 2'd2, 4'hF, 6);
        chk("rd_port_oe", 32'(port_oe), 32'h0);
        chk("rd_err", 32'(err), 32'h0);

        // WRITE 3 F then AND 3 D
        wq.push_back('{3, 4'hF}); bus(2'd1, 2'd3, 4'hF, 6);
        wq.push_back('{3, 4'hD}); bus(2'd3, 2'd3, 4'hD, 6);
        chk("and_port3", 32'(port_out[15:12]), 32'hD);
        chk("wr_port_oe3", 32'(port_oe[3]), 32'h1);

        // WRITE 1 1, OR 1 4, READ 1
        wq.push_back('{1, 4'h1}); bus(2'd1, 2'd1, 4'h1, 6);
        wq.push_back('{1, 4'h5}); bus(2'd2, 2'd1, 4'h4, 6);
        chk("or_port_oe1", 32'(port_oe[1]), 32'h1);
        rq.push_back(4'h5); bus(2'd0, 2'd1, 4'hF, 6);
        chk("rd_clears_oe1", 32'(port_oe[1]), 32'h0);
        chk("port_out_all", 32'(port_out), 32'hDF5F);

        // Short strobe on WRITE 0
        bus(2'd1, 2'd0, 4'h0, 2);
        chk("short_err", 32'(err), 32'h1);
        chk("short_port0", 32'(port_out[3:0]), 32'hF);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'h0);

        // Out-of-range address on the 3-port instance
        chk("p3_port_out_pre", 32'(port_out3), 32'hF5F);
        win3 = 1'b1;
        wq.push_back('{3, 4'h0}); bus(2'd1, 2'd3, 4'h0, 6);
        rq.push_back(4'h0); bus(2'd0, 2'd3, 4'hF, 6);
        win3 = 1'b0;
        chk("p3_no_activity", 32'(bad3), 32'h0);
        chk("p3_port_out", 32'(port_out3), 32'hF5F);
        chk("p3_port_oe", 32'(port_oe3), 32'h0);
        chk("p3_err", 32'(err3), 32'h0);
        chk("port_out_after_p3", 32'(port_out), 32'h0F5F);

        // Reset during WR_WAIT of WRITE 2
        p2_in = {2'd1, 2'd2};
        repeat (2) @(negedge clk);
        prog_n = 1'b0;
        @(negedge clk);
        p2_in = 4'h0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_port_out", 32'(port_out), 32'hFFFF);
        chk("mid_rst_port_oe", 32'(port_oe), 32'h0);
        chk("mid_rst_p2_oe", 32'(p2_oe), 32'h0);
        chk("mid_rst_wr_stb", 32'(wr_stb), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_low_port_out", 32'(port_out), 32'hFFFF);
        prog_n = 1'b1;
        repeat (6) @(negedge clk);
        p2_in = 4'hF;
        wq.push_back('{2, 4'h6}); bus(2'd1, 2'd2, 4'h6, 6);
        chk("post_rst_port_out", 32'(port_out), 32'hF6FF);
        chk("post_rst_port_oe", 32'(port_oe), 32'h4);

        repeat (4) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'h0);
        chk("rq_drained", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
